// File: rtl/data_memory_unit.sv
// Word-addressed load/store unit with a fixed multi-cycle access latency.
// Requests are accepted in IDLE or DONE; busy marks the ACCESS phase for PC stalling.
module data_memory_unit #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        busy,
   output logic        misaligned
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                store_q, store_d;
   logic [31:0]         load_data_q, load_data_d;
   logic                load_valid_q, load_valid_d;
   logic                busy_q, busy_d;
   logic                misaligned_q, misaligned_d;

   logic                req;
   logic                accepting;
   logic                do_access;
   logic                unused_addr_bits;

   logic [31:0]         mem [2**ADDR_W];

   assign req              = mem_read | mem_write;
   assign accepting        = (state_q != ACCESS);
   assign unused_addr_bits = ^addr[31:ADDR_W+2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         store_q      <= 1'b0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         store_q      <= store_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         busy_q       <= busy_d;
         misaligned_q <= misaligned_d;
      end
   end

   // A write-with-read request is a store; misaligned requests fall back to IDLE untouched.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      store_d   = store_q;
      do_access = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (req && (addr[1:0] == 2'b00)) begin
               state_d = ACCESS;
               cnt_d   = 3'(WAIT_STATES);
               waddr_d = addr[ADDR_W+1:2];
               wdata_d = store_data;
               store_d = mem_write;
            end
         end
         ACCESS: begin
            if (cnt_q == 3'd1) begin
               state_d   = DONE;
               do_access = 1'b1;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      misaligned_d = accepting && req && (addr[1:0] != 2'b00);
      load_valid_d = do_access && !store_q;
      busy_d       = (state_d == ACCESS);
      load_data_d  = load_data_q;
      if (do_access && !store_q) begin
         load_data_d = mem[waddr_q];
      end
   end

   // The array is deliberately unreset; an async reset mid-ACCESS clears state_q so no write fires.
   always_ff @(posedge clk) begin
      if (do_access && store_q) begin
         mem[waddr_q] <= wdata_q;
      end
   end

   assign load_data  = load_data_q;
   assign load_valid = load_valid_q;
   assign busy       = busy_q;
   assign misaligned = misaligned_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit (WAIT_STATES=2, ADDR_W=10): a per-cycle
// vector table plus hand-written sequences for DONE-state misalignment and reset mid-access.
module tb_data_memory_unit;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [31:0] load_data;
   logic        load_valid;
   logic        busy;
   logic        misaligned;

   int unsigned errors = 0;
   int unsigned checks = 0;

   data_memory_unit #(
      .ADDR_W      (10),
      .WAIT_STATES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr       (addr),
      .store_data (store_data),
      .load_data  (load_data),
      .load_valid (load_valid),
      .busy       (busy),
      .misaligned (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] e_ld;
      logic        e_lv;
      logic        e_busy;
      logic        e_mis;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rd, logic wr, logic [31:0] a, logic [31:0] d,
                               logic [31:0] e_ld, logic e_lv, logic e_busy, logic e_mis);
      vec_t v;
      v.rd = rd; v.wr = wr; v.a = a; v.d = d;
      v.e_ld = e_ld; v.e_lv = e_lv; v.e_busy = e_busy; v.e_mis = e_mis;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_ld, input logic e_lv,
                          input logic e_busy, input logic e_mis);
      chk({tag, ".load_data"},  load_data,          e_ld);
      chk({tag, ".load_valid"}, {31'd0, load_valid}, {31'd0, e_lv});
      chk({tag, ".busy"},       {31'd0, busy},       {31'd0, e_busy});
      chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, e_mis});
   endtask

   // Drive inputs (called at posedge+1), then advance one edge and settle.
   task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      mem_read   = rd;
      mem_write  = wr;
      addr       = a;
      store_data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      addr       = '0;
      store_data = '0;

      // Store/load 0x10
      vecs.push_back(mk(0, 1, 32'h10,   32'hDEADBEEF, 32'h0,        0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'h0,        0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h10,   32'h0,        32'h0,        0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'h0,        0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'hDEADBEEF, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'hDEADBEEF, 0, 0, 0));
      // Misaligned load from IDLE
      vecs.push_back(mk(1, 0, 32'h13,   32'h0,        32'hDEADBEEF, 0, 0, 1));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'hDEADBEEF, 0, 0, 0));
      // Wrap: 0x1000 aliases word 0
      vecs.push_back(mk(0, 1, 32'h1000, 32'h12345678, 32'hDEADBEEF, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'hDEADBEEF, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'hDEADBEEF, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'hDEADBEEF, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0,    32'h0,        32'hDEADBEEF, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'hDEADBEEF, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'h12345678, 1, 0, 0));
      // Back-to-back store then load in DONE; a store driven during ACCESS is ignored
      vecs.push_back(mk(0, 1, 32'h20,   32'hA5A5A5A5, 32'h12345678, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'h12345678, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'h12345678, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h20,   32'h0,        32'h12345678, 0, 1, 0));
      vecs.push_back(mk(0, 1, 32'h20,   32'h0,        32'h12345678, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'hA5A5A5A5, 1, 0, 0));
      // Read+write together is a store
      vecs.push_back(mk(1, 1, 32'h40,   32'h0F0F0F0F, 32'hA5A5A5A5, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'hA5A5A5A5, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'hA5A5A5A5, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h40,   32'h0,        32'hA5A5A5A5, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'hA5A5A5A5, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'h0F0F0F0F, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,    32'h0,        32'h0F0F0F0F, 0, 0, 0));

      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
         chk_all($sformatf("vec%0d", i), vecs[i].e_ld, vecs[i].e_lv, vecs[i].e_busy, vecs[i].e_mis);
      end

      // Misaligned request presented in DONE: pulse, then IDLE with no access
      step(0, 1, 32'h30, 32'h33333333);
      step(0, 0, 32'h0, 32'h0);
      step(0, 0, 32'h0, 32'h0);
      chk_all("done_pre", 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);
      step(1, 0, 32'h32, 32'h0);
      chk_all("done_mis", 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1);
      step(0, 0, 32'h0, 32'h0);
      chk_all("done_mis_after", 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);

      // Reset mid-access: pre-store, then abort a second store
      step(0, 1, 32'h80, 32'h11111111);
      step(0, 0, 32'h0, 32'h0);
      step(0, 0, 32'h0, 32'h0);
      step(0, 0, 32'h0, 32'h0);
      step(0, 1, 32'h80, 32'h22222222);
      chk_all("abort_busy", 32'h0F0F0F0F, 1'b0, 1'b1, 1'b0);
      mem_write = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk_all("abort_rst", 32'h0, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk_all("abort_idle", 32'h0, 1'b0, 1'b0, 1'b0);
      step(1, 0, 32'h80, 32'h0);
      step(0, 0, 32'h0, 32'h0);
      step(0, 0, 32'h0, 32'h0);
      chk_all("abort_load", 32'h11111111, 1'b1, 1'b0, 1'b0);
      step(0, 0, 32'h0, 32'h0);
      chk_all("abort_hold", 32'h11111111, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
